// File: rtl/mem_arbiter.sv
// Two-requester (I-cache / D-cache) arbiter onto one slow-memory port, D-priority with starvation guard.
// Optional ARB_PERF_CNT_EN adds saturating grant/wait performance counters.
module mem_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          proc_reset,
  input  logic          memI_read,
  input  logic          memI_write,
  input  logic [31:4]   memI_addr,
  input  logic [127:0]  memI_wdata,
  output logic [127:0]  memI_rdata,
  output logic          memI_ready,
  input  logic          memD_read,
  input  logic          memD_write,
  input  logic [31:4]   memD_addr,
  input  logic [127:0]  memD_wdata,
  output logic [127:0]  memD_rdata,
  output logic          memD_ready,
  output logic          mem_read,
  output logic          mem_write,
  output logic [31:4]   mem_addr,
  output logic [127:0]  mem_wdata,
  input  logic [127:0]  mem_rdata,
  input  logic          mem_ready
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [15:0]   cnt_gnt_i,
  output logic [15:0]   cnt_gnt_d,
  output logic [15:0]   cnt_wait
`endif
);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_starve;
  logic       w_i_req;
  logic       w_d_req;

  assign w_i_req = memI_read | memI_write;
  assign w_d_req = memD_read | memD_write;

  always_ff @(posedge clk) begin
    if (proc_reset) r_state <= IDLE;
    else            r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_d_req && w_i_req)
          w_next = (r_starve == 4'(STARVE_MAX)) ? GNT_I : GNT_D;
        else if (w_d_req)
          w_next = GNT_D;
        else if (w_i_req)
          w_next = GNT_I;
      end
      GNT_I:   if (mem_ready) w_next = IDLE;
      GNT_D:   if (mem_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Counts D grants taken while I waits; only updated on IDLE arbitration cycles.
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      r_starve <= '0;
    end else if (r_state == IDLE) begin
      if (w_next == GNT_I || !w_i_req)
        r_starve <= '0;
      else if (w_next == GNT_D && r_starve != 4'(STARVE_MAX))
        r_starve <= r_starve + 4'd1;
    end
  end

  always_comb begin
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    memI_ready = 1'b0;
    memI_rdata = '0;
    memD_ready = 1'b0;
    memD_rdata = '0;
    if (!proc_reset) begin
      case (r_state)
        GNT_I: begin
          mem_read   = memI_read;
          mem_write  = memI_write;
          mem_addr   = memI_addr;
          mem_wdata  = memI_wdata;
          memI_ready = mem_ready;
          memI_rdata = mem_rdata;
        end
        GNT_D: begin
          mem_read   = memD_read;
          mem_write  = memD_write;
          mem_addr   = memD_addr;
          mem_wdata  = memD_wdata;
          memD_ready = mem_ready;
          memD_rdata = mem_rdata;
        end
        default: ;
      endcase
    end
  end

`ifdef ARB_PERF_CNT_EN
  logic [15:0] r_cnt_gnt_i;
  logic [15:0] r_cnt_gnt_d;
  logic [15:0] r_cnt_wait;
  logic        w_wait;

  // A wait cycle is one where the other requester is asserting while a grant is held.
  assign w_wait = ((r_state == GNT_I) && w_d_req) || ((r_state == GNT_D) && w_i_req);

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      r_cnt_gnt_i <= '0;
      r_cnt_gnt_d <= '0;
      r_cnt_wait  <= '0;
    end else begin
      if (r_state == IDLE && w_next == GNT_I && r_cnt_gnt_i != '1)
        r_cnt_gnt_i <= r_cnt_gnt_i + 16'd1;
      if (r_state == IDLE && w_next == GNT_D && r_cnt_gnt_d != '1)
        r_cnt_gnt_d <= r_cnt_gnt_d + 16'd1;
      if (w_wait && r_cnt_wait != '1)
        r_cnt_wait <= r_cnt_wait + 16'd1;
    end
  end

  assign cnt_gnt_i = r_cnt_gnt_i;
  assign cnt_gnt_d = r_cnt_gnt_d;
  assign cnt_wait  = r_cnt_wait;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Table-driven bench for mem_arbiter (STARVE_MAX=2) plus latency sequences.
module tb_mem_arbiter;

  logic          clk;
  logic          proc_reset;
  logic          memI_read, memI_write, memD_read, memD_write;
  logic [31:4]   memI_addr, memD_addr, mem_addr;
  logic [127:0]  memI_wdata, memD_wdata, memI_rdata, memD_rdata;
  logic          memI_ready, memD_ready;
  logic          mem_read, mem_write, mem_ready;
  logic [127:0]  mem_wdata, mem_rdata;
`ifdef ARB_PERF_CNT_EN
  logic [15:0]   cnt_gnt_i, cnt_gnt_d, cnt_wait;
`endif

  int total;
  int bad;

  mem_arbiter #(.STARVE_MAX(2)) dut (
    .clk        (clk),
    .proc_reset (proc_reset),
    .memI_read  (memI_read),
    .memI_write (memI_write),
    .memI_addr  (memI_addr),
    .memI_wdata (memI_wdata),
    .memI_rdata (memI_rdata),
    .memI_ready (memI_ready),
    .memD_read  (memD_read),
    .memD_write (memD_write),
    .memD_addr  (memD_addr),
    .memD_wdata (memD_wdata),
    .memD_rdata (memD_rdata),
    .memD_ready (memD_ready),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
`ifdef ARB_PERF_CNT_EN
    ,
    .cnt_gnt_i  (cnt_gnt_i),
    .cnt_gnt_d  (cnt_gnt_d),
    .cnt_wait   (cnt_wait)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       ir;
    logic       iw;
    logic       dr;
    logic       dw;
    logic       rdy;
    logic [1:0] gnt;   // expected grant seen by this row: 0 none, 1 I, 2 D
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int row, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row=%0d actual=%h required=%h", name, row, act, exp);
    end
  endtask

  task automatic add(input logic rst, ir, iw, dr, dw, rdy, input logic [1:0] gnt);
    vec_t v;
    v.rst = rst; v.ir = ir; v.iw = iw; v.dr = dr; v.dw = dw; v.rdy = rdy; v.gnt = gnt;
    vecs.push_back(v);
  endtask

  initial begin
    logic [31:4]  e_addr;
    logic [127:0] e_wdata;
    logic         e_rd, e_wr;
    int           lat;
    int           m_gi, m_gd, m_wait;
    logic [1:0]   prev_gnt;

    total = 0; bad = 0;
    proc_reset = 1'b1;
    memI_read = 0; memI_write = 0; memD_read = 0; memD_write = 0; mem_ready = 0;
    memI_addr  = 28'h0000010;
    memD_addr  = 28'h0000020;
    memI_wdata = 128'h11111111_22222222_33333333_44444444;
    memD_wdata = 128'hDDDDDDDD_EEEEEEEE_FFFFFFFF_00000000;
    mem_rdata  = '0;

    //   rst ir iw dr dw rdy gnt
    add(1, 0, 0, 0, 0, 0, 0);   // reset
    add(0, 1, 0, 0, 0, 0, 0);   // I read arrives in IDLE
    add(0, 1, 0, 0, 0, 0, 1);
    add(0, 1, 0, 0, 0, 0, 1);
    add(0, 1, 0, 0, 0, 0, 1);
    add(0, 1, 0, 0, 0, 0, 1);
    add(0, 1, 0, 0, 0, 1, 1);   // 5th strobe cycle, ready
    add(0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0);   // stray ready in IDLE
    add(0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 1, 0, 0, 0);   // simultaneous: D first
    add(0, 1, 0, 1, 0, 0, 2);
    add(0, 1, 0, 1, 0, 1, 2);
    add(0, 1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 1, 1);
    add(0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 1, 0, 0, 0);   // starvation: D,D,I,D,D,I
    add(0, 1, 0, 1, 0, 1, 2);
    add(0, 1, 0, 1, 0, 0, 0);
    add(0, 1, 0, 1, 0, 1, 2);
    add(0, 1, 0, 1, 0, 0, 0);
    add(0, 1, 0, 1, 0, 1, 1);
    add(0, 1, 0, 1, 0, 0, 0);
    add(0, 1, 0, 1, 0, 1, 2);
    add(0, 1, 0, 1, 0, 0, 0);
    add(0, 1, 0, 1, 0, 1, 2);
    add(0, 1, 0, 1, 0, 0, 0);
    add(0, 1, 0, 1, 0, 1, 1);
    add(0, 1, 1, 0, 0, 0, 0);   // read+write together forwarded
    add(0, 1, 1, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 1);   // strobe dropped, grant held
    add(0, 0, 0, 0, 0, 1, 1);
    add(0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0);   // D write-back then refill
    add(0, 0, 0, 0, 1, 1, 2);
    add(0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 2);
    add(0, 0, 0, 1, 0, 0, 2);
    add(1, 0, 0, 1, 0, 0, 0);   // reset in GNT_D cycle 3
    add(0, 1, 0, 1, 0, 0, 0);
    add(0, 1, 0, 1, 0, 1, 2);
    add(0, 1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 1, 1);
    add(0, 0, 0, 0, 0, 0, 0);

    m_gi = 0; m_gd = 0; m_wait = 0; prev_gnt = 2'd0;
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      proc_reset = vecs[i].rst;
      memI_read  = vecs[i].ir;
      memI_write = vecs[i].iw;
      memD_read  = vecs[i].dr;
      memD_write = vecs[i].dw;
      mem_ready  = vecs[i].rdy;
      mem_rdata  = {4{32'hA5A50000 ^ 32'(i)}};
      #1;
      e_rd    = (vecs[i].gnt == 2'd1) ? vecs[i].ir : (vecs[i].gnt == 2'd2) ? vecs[i].dr : 1'b0;
      e_wr    = (vecs[i].gnt == 2'd1) ? vecs[i].iw : (vecs[i].gnt == 2'd2) ? vecs[i].dw : 1'b0;
      e_addr  = (vecs[i].gnt == 2'd1) ? memI_addr  : (vecs[i].gnt == 2'd2) ? memD_addr  : '0;
      e_wdata = (vecs[i].gnt == 2'd1) ? memI_wdata : (vecs[i].gnt == 2'd2) ? memD_wdata : '0;
      chk("mem_read",   i, 128'(mem_read),   128'(e_rd));
      chk("mem_write",  i, 128'(mem_write),  128'(e_wr));
      chk("mem_addr",   i, 128'(mem_addr),   128'(e_addr));
      chk("mem_wdata",  i, mem_wdata,        e_wdata);
      chk("memI_ready", i, 128'(memI_ready), 128'((vecs[i].gnt == 2'd1) && vecs[i].rdy));
      chk("memD_ready", i, 128'(memD_ready), 128'((vecs[i].gnt == 2'd2) && vecs[i].rdy));
      chk("memI_rdata", i, memI_rdata, (vecs[i].gnt == 2'd1) ? {4{32'hA5A50000 ^ 32'(i)}} : 128'd0);
      chk("memD_rdata", i, memD_rdata, (vecs[i].gnt == 2'd2) ? {4{32'hA5A50000 ^ 32'(i)}} : 128'd0);
      if (vecs[i].rst) begin
        m_gi = 0; m_gd = 0; m_wait = 0;
      end else begin
        if (prev_gnt == 2'd0 && vecs[i].gnt == 2'd1) m_gi++;
        if (prev_gnt == 2'd0 && vecs[i].gnt == 2'd2) m_gd++;
        if ((vecs[i].gnt == 2'd1 && (vecs[i].dr || vecs[i].dw)) ||
            (vecs[i].gnt == 2'd2 && (vecs[i].ir || vecs[i].iw))) m_wait++;
      end
      prev_gnt = vecs[i].gnt;
    end

`ifdef ARB_PERF_CNT_EN
    @(negedge clk);
    chk("cnt_gnt_i", 0, 128'(cnt_gnt_i), 128'(m_gi));
    chk("cnt_gnt_d", 0, 128'(cnt_gnt_d), 128'(m_gd));
    chk("cnt_wait",  0, 128'(cnt_wait),  128'(m_wait));
`endif

    // Request-to-strobe latency: one edge from an IDLE request.
    @(negedge clk);
    memD_read = 1'b1; mem_ready = 1'b0;
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (mem_read) begin lat = k; break; end
    end
    chk("req_latency", 100, 128'(lat), 128'd1);

    // Ready-to-next-grant spacing: ready edge, one IDLE edge, then I grant.
    @(negedge clk);
    mem_ready = 1'b1; memD_read = 1'b0; memI_read = 1'b1;
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      mem_ready = 1'b0;
      if (mem_read) begin lat = k; break; end
    end
    chk("ready_to_grant", 101, 128'(lat), 128'd2);
    chk("grant_is_I", 101, 128'(mem_addr), 128'(memI_addr));

    @(negedge clk);
    mem_ready = 1'b1;
    #1;
    chk("final_I_ready", 102, 128'(memI_ready), 128'd1);
    @(negedge clk);
    memI_read = 1'b0; mem_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
